dmi_reg_target: RTL

- Core-clock DMI responder: the far end of the DMI request/response handshake produced by the JTAG DTM and CDC.
- Accepts dm::dmi_req_t requests and returns dm::dmi_resp_t responses.
- Implements a bank of scratch registers and a read-only ID word.
- Has a programmable response latency, so DTM busy/timing paths can be exercised on FPGA and in simulation without a full debug module.

---
 rtl/dm_pkg.sv | 25 ++
 rtl/dmi_reg_target_pkg.sv | 23 ++
 rtl/dmi_reg_target_bank.sv | 47 ++++
 rtl/dmi_reg_target.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Debug-module DMI types shared between the DTM/CDC and core-side responders.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_reg_target_pkg.sv
// Shared constants and decode helper for the dmi_reg_target DMI responder.
package dmi_reg_target_pkg;

    // Responder FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h1BEE_F001;
    localparam logic [31:0] BUSY_DATA        = 32'hB051_B051;
    localparam logic [31:0] ERR_DATA         = 32'h0000_0000;

    // True when addr falls inside [base, base+num); the base comparison stops
    // the 7-bit subtraction from wrapping low addresses into the bank.
    function automatic logic addr_in_range(input logic [6:0] addr,
                                           input logic [6:0] base,
                                           input logic [5:0] num);
        logic [6:0] idx;
        idx = addr - base;
        return (addr >= base) && (idx < {1'b0, num});
    endfunction

endpackage

// File: rtl/dmi_reg_target_bank.sv
// Scratch register bank: single write port, indexed read, flattened view.
module dmi_reg_target_bank #(
    parameter int unsigned NumRegs = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [6:0]            widx_i,
    input  logic [31:0]           wdata_i,
    input  logic [6:0]            ridx_i,
    output logic [NumRegs*32-1:0] regs_o,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_r [NumRegs];
    logic [31:0] rdata_s;

    // Register storage; a write lands only on the addressed entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                if (we_i && (widx_i == 7'(i))) begin
                    mem_r[i] <= wdata_i;
                end
            end
        end
    end

    // AND-OR read mux; an index outside the bank yields zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        for (int i = 0; i < int'(NumRegs); i++) begin
            rdata_s = rdata_s | ({32{ridx_i == 7'(i)}} & mem_r[i]);
        end
    end

    for (genvar g = 0; g < int'(NumRegs); g++) begin : g_flat
        assign regs_o[g*32 +: 32] = mem_r[g];
    end

    assign rdata_o = rdata_s;

endmodule

// File: rtl/dmi_reg_target.sv
// Core-clock DMI responder with scratch registers, an ID word and a
// programmable response latency. Optional macro DMI_REG_TARGET_BUSY_INJECT_EN
// adds busy_inject_i, which forces a DTM_BUSY response for the accepted request.
module dmi_reg_target
    import dmi_reg_target_pkg::*;
#(
    parameter int unsigned NumRegs     = 8,
    parameter logic [6:0]  BaseAddr    = 7'h04,
    parameter logic [6:0]  IdAddr      = 7'h7F,
    parameter logic [31:0] IdValue     = DEFAULT_ID_VALUE,
    parameter int unsigned RespLatency = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef DMI_REG_TARGET_BUSY_INJECT_EN
    input  logic                  busy_inject_i,
`endif
    input  dm::dmi_req_t          dmi_req_i,
    input  logic                  dmi_req_valid_i,
    output logic                  dmi_req_ready_o,
    output dm::dmi_resp_t         dmi_resp_o,
    output logic                  dmi_resp_valid_o,
    input  logic                  dmi_resp_ready_i,
    output logic [NumRegs*32-1:0] regs_o,
    output logic [7:0]            err_count_o
);

    logic [1:0]    state_r;
    logic [3:0]    cnt_r;
    dm::dmi_resp_t resp_r;
    logic [7:0]    err_count_r;

    logic          accept_s;
    logic          in_range_s;
    logic [6:0]    idx_s;
    logic [31:0]   rdata_s;
    logic          busy_s;
    logic [1:0]    dec_resp_s;
    logic [31:0]   dec_data_s;
    logic          dec_wr_s;
    logic          dec_err_s;
    logic [1:0]    resp_code_s;
    logic [31:0]   resp_data_s;
    logic          wr_en_s;
    logic          err_s;

    assign accept_s   = dmi_req_valid_i && (state_r == ST_IDLE);
    assign idx_s      = dmi_req_i.addr - BaseAddr;
    assign in_range_s = addr_in_range(dmi_req_i.addr, BaseAddr, 6'(NumRegs));

`ifdef DMI_REG_TARGET_BUSY_INJECT_EN
    assign busy_s = busy_inject_i;
`else
    assign busy_s = 1'b0;
`endif

    // Decode the presented request into response code/data and side effects
    always_comb begin
        dec_resp_s = dm::DTM_ERR;
        dec_data_s = ERR_DATA;
        dec_wr_s   = 1'b0;
        dec_err_s  = 1'b1;
        case (dmi_req_i.op)
            dm::DTM_NOP: begin
                dec_resp_s = dm::DTM_SUCCESS;
                dec_data_s = 32'h0000_0000;
                dec_err_s  = 1'b0;
            end
            dm::DTM_READ: begin
                if (in_range_s) begin
                    dec_resp_s = dm::DTM_SUCCESS;
                    dec_data_s = rdata_s;
                    dec_err_s  = 1'b0;
                end else if (dmi_req_i.addr == IdAddr) begin
                    dec_resp_s = dm::DTM_SUCCESS;
                    dec_data_s = IdValue;
                    dec_err_s  = 1'b0;
                end else begin
                    dec_err_s  = 1'b1;
                end
            end
            dm::DTM_WRITE: begin
                if (in_range_s) begin
                    dec_resp_s = dm::DTM_SUCCESS;
                    dec_data_s = dmi_req_i.data;
                    dec_wr_s   = 1'b1;
                    dec_err_s  = 1'b0;
                end else begin
                    dec_err_s  = 1'b1;
                end
            end
            default: begin
                dec_err_s = 1'b1;
            end
        endcase
    end

    // Busy injection overrides the decode and suppresses all side effects
    assign resp_code_s = busy_s ? dm::DTM_BUSY : dec_resp_s;
    assign resp_data_s = busy_s ? BUSY_DATA : dec_data_s;
    assign wr_en_s     = accept_s && dec_wr_s && !busy_s;
    assign err_s       = dec_err_s && !busy_s;

    dmi_reg_target_bank #(
        .NumRegs (NumRegs)
    ) u_bank (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (wr_en_s),
        .widx_i  (idx_s),
        .wdata_i (dmi_req_i.data),
        .ridx_i  (idx_s),
        .regs_o  (regs_o),
        .rdata_o (rdata_s)
    );

    // Transaction FSM: accept, count down the latency, hold until handshake
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r   <= 4'(RespLatency);
                        state_r <= (RespLatency != 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (dmi_resp_ready_i) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Response word is captured at accept so it stays stable while waiting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_r <= '0;
        end else if (accept_s) begin
            resp_r.resp <= resp_code_s;
            resp_r.data <= resp_data_s;
        end
    end

    // Saturating count of error responses, bumped at the accept edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_count_r <= 8'h00;
        end else if (accept_s && err_s && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'h01;
        end
    end

    assign dmi_req_ready_o  = (state_r == ST_IDLE);
    assign dmi_resp_valid_o = (state_r == ST_RESP);
    assign dmi_resp_o       = resp_r;
    assign err_count_o      = err_count_r;

endmodule
